serial_match_ctrl: RTL and testbench

Frame-level controller that sequences the serial "11" pattern detector. It loads a parallel word, shifts it MSB-first through an internal detector one bit per clock, and counts the detector's output pulses. It then reports the match count with a busy/done handshake. It sits between a parallel producer and the detector, so a word can be checked with a single `start` strobe.

---
 rtl/serial_match_pkg.sv | 27 ++
 rtl/serial_match_ctrl_detect_11.sv | 58 +++++
 rtl/serial_match_ctrl.sv | 126 ++++++++++++
 tb/tb_serial_match_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_match_pkg.sv
// -----------------------------------------------------------------------------
// serial_match_pkg
// Shared encodings for the serial "11" match controller and its detector.
//   ctrl_state_t : controller FSM state (IDLE, SHIFT, DRAIN, DONE), 2 bits
//   det_state_t  : detector state (A = cleared, B = last bit 0, C = last bit 1)
//   is_busy_state: helper that tells whether a controller state owns a frame
// -----------------------------------------------------------------------------
package serial_match_pkg;

    typedef logic [1:0] ctrl_state_t;
    typedef logic [1:0] det_state_t;

    localparam ctrl_state_t CTRL_IDLE  = 2'b00;
    localparam ctrl_state_t CTRL_SHIFT = 2'b01;
    localparam ctrl_state_t CTRL_DRAIN = 2'b10;
    localparam ctrl_state_t CTRL_DONE  = 2'b11;

    localparam det_state_t DET_A = 2'b00;
    localparam det_state_t DET_B = 2'b01;
    localparam det_state_t DET_C = 2'b10;

    // A frame is in flight while bits are shifting or the last output drains.
    function automatic logic is_busy_state(input ctrl_state_t s);
        return (s == CTRL_SHIFT) || (s == CTRL_DRAIN);
    endfunction

endpackage

// File: rtl/serial_match_ctrl_detect_11.sv
// -----------------------------------------------------------------------------
// detect_11
// Serial "11" pattern detector with a registered output. y_out pulses for one
// cycle after the second of two consecutive 1s; overlapping matches count.
// Ports:
//   clk   in  : rising-edge clock
//   reset in  : synchronous active-high reset (state A, y_out = 0)
//   clr   in  : synchronous clear to state A with y_out = 0
//   x_in  in  : serial input bit
//   y_out out : registered match pulse
// -----------------------------------------------------------------------------
module detect_11
    import serial_match_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic x_in,
    output logic y_out
);

    det_state_t state_q;
    det_state_t state_d;
    logic       y_q;
    logic       y_d;

    // Next state: the state only remembers the last bit; the output fires
    // when the remembered bit and the current bit are both 1.
    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        if (clr) begin
            state_d = DET_A;
            y_d     = 1'b0;
        end else begin
            y_d = (state_q == DET_C) && x_in;
            if (x_in) begin
                state_d = DET_C;
            end else begin
                state_d = DET_B;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= DET_A;
            y_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
        end
    end

    assign y_out = y_q;

endmodule

// File: rtl/serial_match_ctrl.sv
// -----------------------------------------------------------------------------
// serial_match_ctrl
// Loads a parallel word on an accepted start, shifts it MSB-first through a
// detect_11 instance one bit per clock, counts the detector's pulses and
// reports the count with a busy/done handshake.
// Ports:
//   clk         in  : rising-edge clock
//   reset       in  : synchronous active-high reset
//   start       in  : frame request, accepted only in IDLE
//   data_in     in  : frame word, captured on the accepting edge
//   x_out       out : bit currently presented to the detector (0 outside SHIFT)
//   busy        out : high while shifting and draining
//   done        out : one-cycle pulse when match_count is final
//   match_count out : matches in the last completed frame
// -----------------------------------------------------------------------------
module serial_match_ctrl
    import serial_match_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic             x_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] match_count
);

    localparam int BCW = $clog2(WIDTH);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);

    ctrl_state_t      state_q;
    ctrl_state_t      state_d;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;
    logic [BCW-1:0]   bit_cnt_q;
    logic [BCW-1:0]   bit_cnt_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             det_clr_s;
    logic             det_y_s;
    logic             accept_s;

    assign accept_s = (state_q == CTRL_IDLE) && start;

    // The detector is held cleared everywhere except SHIFT, so no history
    // leaks across frames; the accept term also clears it on edge 0.
    assign det_clr_s = accept_s || (state_q != CTRL_SHIFT);

    detect_11 u_detect (
        .clk   (clk),
        .reset (reset),
        .clr   (det_clr_s),
        .x_in  (x_out),
        .y_out (det_y_s)
    );

    // Controller next-state, shift register, bit counter and match counter.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        count_d   = count_q;
        case (state_q)
            CTRL_IDLE: begin
                if (start) begin
                    state_d   = CTRL_SHIFT;
                    shreg_d   = data_in;
                    bit_cnt_d = {BCW{1'b0}};
                    count_d   = {CNT_W{1'b0}};
                end else begin
                    state_d = CTRL_IDLE;
                end
            end
            CTRL_SHIFT: begin
                shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                if (bit_cnt_q == LAST_BIT) begin
                    state_d   = CTRL_DRAIN;
                    bit_cnt_d = {BCW{1'b0}};
                end else begin
                    bit_cnt_d = bit_cnt_q + BCW'(1);
                end
            end
            CTRL_DRAIN: begin
                state_d = CTRL_DONE;
            end
            CTRL_DONE: begin
                state_d = CTRL_IDLE;
            end
            default: begin
                state_d = CTRL_IDLE;
            end
        endcase
        // The detector output lags its input by one edge; DRAIN exists so
        // the pulse for the last bit is still counted here.
        if (is_busy_state(state_q) && det_y_s) begin
            count_d = count_q + CNT_W'(1);
        end else begin
            count_d = count_d;
        end
    end

    // Controller registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= CTRL_IDLE;
            shreg_q   <= {WIDTH{1'b0}};
            bit_cnt_q <= {BCW{1'b0}};
            count_q   <= {CNT_W{1'b0}};
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            count_q   <= count_d;
        end
    end

    assign x_out       = (state_q == CTRL_SHIFT) && shreg_q[WIDTH-1];
    assign busy        = is_busy_state(state_q);
    assign done        = (state_q == CTRL_DONE);
    assign match_count = count_q;

endmodule

// File: tb/tb_serial_match_ctrl.sv
module tb_serial_match_ctrl;

    localparam int W     = 8;
    localparam int CNT_W = 4;
    localparam int FRAME = W + 3;   // cycles from one accept to the next

    logic             clk;
    logic             reset;
    logic             start;
    logic [W-1:0]     data_in;
    logic             x_out;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] match_count;

    int n_checks;
    int n_errors;
    int edge_cnt;
    int accept_edge;
    int prev_accept;
    logic [W-1:0] hist [0:4095];

    serial_match_ctrl #(.WIDTH(W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .data_in     (data_in),
        .x_out       (x_out),
        .busy        (busy),
        .done        (done),
        .match_count (match_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Watchdog so the run can never hang.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: number of adjacent bit pairs that are both 1.
    function automatic int count_pairs(input logic [W-1:0] d);
        int n;
        n = 0;
        for (int i = 0; i < W - 1; i++) begin
            if (d[i] && d[i+1]) n++;
        end
        return n;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Request a frame, check the full handshake, return just after done.
    task automatic run_frame(input logic [W-1:0] d, input string tag);
        int waited;
        int busy_n;
        int done_at;
        logic [W-1:0] xs;
        start   = 1'b1;
        data_in = d;
        waited  = 0;
        do begin
            tick();
            waited++;
        end while (!busy && waited < W + 4);
        check_eq({tag, "_accept"}, busy, 1);
        prev_accept = accept_edge;
        accept_edge = edge_cnt;
        start   = 1'b0;
        data_in = W'($urandom);
        check_eq({tag, "_cnt_clr"}, match_count, 0);
        check_eq({tag, "_done_low"}, done, 0);
        busy_n  = 0;
        done_at = -1;
        xs      = '0;
        for (int k = 0; k < 3 * W && done_at < 0; k++) begin
            if (busy) busy_n++;
            if (k < W) xs[W-1-k] = x_out;
            if (k == W) check_eq({tag, "_x_drain"}, x_out, 0);
            if (done) done_at = k;
            if (done_at < 0) tick();
        end
        check_eq({tag, "_busy_len"}, busy_n, W + 1);
        check_eq({tag, "_x_seq"}, xs, d);
        check_eq({tag, "_done_at"}, done_at, W + 1);
        check_eq({tag, "_busy_at_done"}, busy, 0);
        check_eq({tag, "_count"}, match_count, count_pairs(d));
    endtask

    initial begin
        int s;
        int rel;
        int dn;
        logic [W-1:0] rd;
        logic exp_done;
        logic exp_busy;
        n_checks    = 0;
        n_errors    = 0;
        accept_edge = 0;
        prev_accept = 0;
        reset   = 1'b1;
        start   = 1'b0;
        data_in = '0;
        repeat (3) tick();
        reset = 1'b0;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_x", x_out, 0);
        check_eq("rst_count", match_count, 0);

        // Directed frames.
        run_frame(8'hFF, "ff");
        run_frame(8'h00, "b2b_00");
        run_frame(8'hAA, "b2b_aa");
        check_eq("b2b_spacing", accept_edge - prev_accept, FRAME);
        repeat (3) tick();
        check_eq("hold_count", match_count, 0);
        run_frame(8'h66, "x66");
        run_frame(8'hC3, "xc3");
        repeat (2) tick();

        // start held high while data_in changes every cycle.
        s     = edge_cnt + 1;
        start = 1'b1;
        for (int c = 0; c < 3 * FRAME; c++) begin
            data_in = W'($urandom);
            hist[(edge_cnt + 1) & 4095] = data_in;
            tick();
            rel      = edge_cnt - s;
            exp_done = ((rel % FRAME) == W + 1);
            exp_busy = ((rel % FRAME) <= W);
            check_eq("held_done", done, exp_done);
            check_eq("held_busy", busy, exp_busy);
            if (exp_done) begin
                check_eq("held_count", match_count, count_pairs(hist[(edge_cnt - (W + 1)) & 4095]));
            end
        end
        start = 1'b0;
        tick();

        // Reset four edges into a frame.
        start   = 1'b1;
        data_in = 8'hFF;
        tick();
        start = 1'b0;
        check_eq("midrst_pre_busy", busy, 1);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_count", match_count, 0);
        check_eq("midrst_x", x_out, 0);
        dn = 0;
        repeat (W + 4) begin
            tick();
            if (done) dn++;
        end
        check_eq("midrst_no_done", dn, 0);
        run_frame(8'h0F, "x0f");
        tick();

        // Reset and start on the same edge.
        reset   = 1'b1;
        start   = 1'b1;
        data_in = 8'hFF;
        tick();
        check_eq("rst_start_busy0", busy, 0);
        reset = 1'b0;
        start = 1'b0;
        tick();
        check_eq("rst_start_busy1", busy, 0);
        check_eq("rst_start_count", match_count, 0);

        // Randomized frames with random idle gaps.
        for (int f = 0; f < 20; f++) begin
            rd = W'($urandom);
            run_frame(rd, "rand");
            repeat ($urandom_range(0, 3)) tick();
            check_eq("rand_hold", match_count, count_pairs(rd));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
